dmem_lat: RTL and testbench
===========================

Name: dmem_lat

Overview:
Parametrised successor to the single-cycle data memory behind the core's data port. It adds configurable width, depth and read latency, byte-enable writes, and a base-address window with out-of-range/misaligned error reporting. A post-reset clear sequence is gated by a ready handshake. It sits between the core's load/store port and the testbed, and is a drop-in for the plain data memory when RD_LAT=1 and INIT_CLEAR=0.

Parameters:
DATA_W, 32, word width in bits; multiple of 8.
ADDR_W, 32, byte-address width.
DEPTH, 64, number of words; power of two ≥ 2.
RD_LAT, 2, read latency in cycles, legal range 1..4.
BASE_ADDR, 0, byte address of word 0; aligned to DATA_W/8.
INIT_CLEAR, 1, 1 = zero all words after every reset before accepting requests.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_req  in  1  request valid.
i_wen  in  1  1 = write, 0 = read; qualified by i_req.
i_addr  in  ADDR_W  byte address.
i_be  in  DATA_W/8  byte enables for writes; bit b controls bits [8b+7:8b].
i_wdata  in  DATA_W  write data.
o_ready  out  1  block accepts a request this cycle.
o_rvalid  out  1  read response valid (one-cycle pulse per accepted read).
o_rdata  out  DATA_W  read data; 0 whenever o_rvalid=0.
o_err  out  1  error pulse for an accepted request, aligned to response timing.

Behaviour:
- Reset: single clock i_clk; reset is asynchronous, active-low on i_rst_n.
  - Reset values: o_rvalid=0, o_rdata=0, o_err=0, all pipeline valids=0.
  - o_ready=0 when INIT_CLEAR=1; o_ready=1 when INIT_CLEAR=0.
- FSM states: INIT, RUN.
  - Reset enters INIT if INIT_CLEAR=1, otherwise RUN.
  - INIT: a clear counter 0..DEPTH-1 writes 0 to one word per cycle. After DEPTH cycles the FSM moves to RUN, so o_ready goes high exactly DEPTH cycles after reset deassertion.
  - RUN: o_ready=1 permanently; the FSM stays in RUN until the next reset.
- Accept: a request is accepted on an edge where i_req=1 and o_ready=1.
  - i_req while o_ready=0 is dropped silently: no write, no response.
- Decode:
  - off = i_addr - BASE_ADDR, computed as unsigned ADDR_W-bit arithmetic, so addresses below BASE wrap to large values and count as out of range.
  - idx = off >> log2(DATA_W/8).
  - Error if the low log2(DATA_W/8) bits of off ≠ 0 (misaligned) or idx ≥ DEPTH (out of range).
- Write: takes effect at the accept edge; only enabled bytes are updated. Errored writes modify nothing. i_be=0 is a legal no-op.
- Read: the array is sampled at the accept edge, then delayed through RD_LAT-1 further register stages.
  - Accepted at edge t: o_rvalid=1 with data during the cycle after edge t+RD_LAT-1. For RD_LAT=1 this is the cycle immediately after the accept edge.
  - Errored reads return o_rdata=0 with o_rvalid=1 and o_err=1.
- Errored writes: o_err pulses with the same RD_LAT timing; o_rvalid stays 0.
- Throughput: one request per cycle, fully pipelined. Responses are returned in order.
- Hazards: a write at edge t is visible to a read accepted at edge t+1 or later. A single port means no simultaneous read and write to resolve.
- i_be is ignored for reads. i_wdata is ignored when i_wen=0.
- Reset mid-operation:
  - All in-flight responses are discarded immediately (asynchronous clear); no stale o_rvalid appears after reset.
  - The FSM returns to INIT and the clear sequence reruns. With INIT_CLEAR=0, contents are retained.
- Memory array itself has no reset; only INIT clears it.

Decomposition:
- Package dmem_pkg holds:
  - state enum {INIT, RUN};
  - derived localparams: BYTES=DATA_W/8, OFF_W=$clog2(BYTES), IDX_W=$clog2(DEPTH);
  - a decode function returning {err, idx}.
- One sub-module, dmem_rd_pipe: a parametrised shift register carrying {valid, err, data} through RD_LAT-1 stages, with asynchronous clear of valid/err/data.
- The top holds the FSM, clear counter, array and decode.

Test Plan:
1. Reset with INIT_CLEAR=1, DEPTH=64: o_ready=0 for exactly 64 cycles, then 1. Read 0x10 -> o_rvalid 2 cycles after the accept edge, o_rdata=0x00000000, o_err=0.
2. Write 0x12345678 to 0x04 with be=4'b1111, then read 0x04 next cycle -> o_rdata=0x12345678 at RD_LAT=2.
3. Write 0xAABBCCDD to 0x04 with be=4'b0101 over test 2's data, then read -> o_rdata=0x12BB56DD.
4. Back-to-back reads of 0x00, 0x04, 0x08 on consecutive cycles (preloaded 1, 2, 3) -> three consecutive o_rvalid cycles carrying 1, 2, 3 in order.
5. Error cases:
   - Read 0x102 (misaligned) -> o_rvalid=1, o_err=1, o_rdata=0.
   - Read 0x100 (idx 64, out of range) -> same.
   - Write 0xFFFFFFFF to 0x100 -> o_err pulse, o_rvalid=0, word 0 unchanged.
   - Repeat with BASE_ADDR=0x1000 and address 0xFFC -> error.
6. Assert i_rst_n low with two reads in flight -> o_rvalid/o_err drop immediately and no responses follow. After release, o_ready is low for 64 cycles, and a read of 0x04 returns 0. Also repeat 1–4 with RD_LAT=1 and RD_LAT=4.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and address decode for the dmem_lat data memory
//   state_t     - INIT (post-reset clear) / RUN (accepting requests)
//   dec_t       - decode result {err, idx}
//   dmem_decode - splits a byte offset into word index plus misaligned/out-of-range error
package dmem_pkg;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic        err;
        logic [63:0] idx;
    } dec_t;

    // off is the already-rebased byte offset; any nonzero low bit is misaligned,
    // and an index past the array (including wrapped sub-base addresses) is out of range.
    function automatic dec_t dmem_decode(input logic [63:0] off, input int off_w, input int depth);
        dec_t d;
        d.idx = off >> off_w;
        d.err = ((off & ((64'd1 << off_w) - 64'd1)) != 64'd0) || (d.idx >= 64'(depth));
        return d;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store port between the core (master) and dmem_lat (slave)
//   i_req/i_wen/i_addr/i_be/i_wdata - request from the core
//   o_ready/o_rvalid/o_rdata/o_err  - acceptance and in-order responses from the memory
interface dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  i_req;
    logic                  i_wen;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W/8-1:0]   i_be;
    logic [DATA_W-1:0]     i_wdata;
    logic                  o_ready;
    logic                  o_rvalid;
    logic [DATA_W-1:0]     o_rdata;
    logic                  o_err;

    modport master (
        output i_req, i_wen, i_addr, i_be, i_wdata,
        input  o_ready, o_rvalid, o_rdata, o_err
    );

    modport slave (
        input  i_req, i_wen, i_addr, i_be, i_wdata,
        output o_ready, o_rvalid, o_rdata, o_err
    );
endinterface

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: response delay line of STAGES registers carrying {valid, err, data}
//   i_clk, i_rst_n          - clock, async active-low clear of every stage
//   i_valid/i_err/i_data    - response entering stage 0 (stage 0 samples the array read)
//   o_valid/o_err/o_data    - response leaving the last stage
module dmem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    logic              r_v [STAGES];
    logic              r_e [STAGES];
    logic [DATA_W-1:0] r_d [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_v[s] <= 1'b0;
                r_e[s] <= 1'b0;
                r_d[s] <= '0;
            end
        end else begin
            r_v[0] <= i_valid;
            r_e[0] <= i_err;
            r_d[0] <= i_data;
            for (int s = 1; s < STAGES; s++) begin
                r_v[s] <= r_v[s-1];
                r_e[s] <= r_e[s-1];
                r_d[s] <= r_d[s-1];
            end
        end
    end

    assign o_valid = r_v[STAGES-1];
    assign o_err   = r_e[STAGES-1];
    assign o_data  = r_d[STAGES-1];

endmodule

// File: rtl/dmem_lat.sv
// dmem_lat: byte-enable data memory with base-address window, RD_LAT-cycle pipelined reads
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   bus (slave)    - request in (req/wen/addr/be/wdata), ready + in-order response out
// Supported: 8 <= DATA_W (multiple of 8), ADDR_W <= 64, DEPTH power of two >= 2, RD_LAT 1..4.
module dmem_lat
    import dmem_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter int              ADDR_W     = 32,
    parameter int              DEPTH      = 64,
    parameter int              RD_LAT     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter bit              INIT_CLEAR = 1'b1
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    dmem_if.slave bus
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [IDX_W-1:0]  r_clr;
    logic              r_ready;

    logic [ADDR_W-1:0] w_off;
    dec_t              w_dec;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic              w_acc;
    logic              w_rd;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign w_off    = bus.i_addr - BASE_ADDR;
    assign w_dec    = dmem_decode(64'(w_off), OFF_W, DEPTH);
    assign w_idx    = w_dec.idx[IDX_W-1:0];
    assign w_err    = w_dec.err;
    assign w_unused = ^w_dec.idx[63:IDX_W];

    // Reset gating keeps a held-in-reset INIT_CLEAR=0 instance from writing the array.
    assign w_acc   = bus.i_req & r_ready & i_rst_n;
    assign w_rd    = w_acc & ~bus.i_wen;
    assign w_rdata = (w_rd & ~w_err) ? r_mem[w_idx] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT_CLEAR ? INIT : RUN;
            r_ready <= !INIT_CLEAR;
            r_clr   <= '0;
        end else if (r_state == INIT) begin
            r_clr <= r_clr + 1'b1;
            if (r_clr == IDX_W'(DEPTH - 1)) begin
                r_state <= RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // Array has no reset; INIT sweeps one word per cycle through the only write port.
    always_ff @(posedge i_clk) begin
        if (r_state == INIT)
            r_mem[r_clr] <= '0;
        else if (w_acc && bus.i_wen && !w_err)
            for (int b = 0; b < BYTES; b++)
                if (bus.i_be[b])
                    r_mem[w_idx][8*b +: 8] <= bus.i_wdata[8*b +: 8];
    end

    // Errored writes travel the same pipe with valid low so o_err lines up with read timing.
    dmem_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT)
    ) u_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (w_rd),
        .i_err   (w_acc & w_err),
        .i_data  (w_rdata),
        .o_valid (bus.o_rvalid),
        .o_err   (bus.o_err),
        .o_data  (bus.o_rdata)
    );

    assign bus.o_ready = r_ready;

endmodule

// File: tb/tb_dmem_lat.sv
// tb_dmem_lat: directed checks of dmem_lat in four configurations sharing one stimulus bus
//   DUT0 RD_LAT=2, DUT1 RD_LAT=1, DUT2 RD_LAT=4, DUT3 RD_LAT=2 BASE_ADDR=0x1000; all DEPTH=64, INIT_CLEAR=1
module tb_dmem_lat;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  be, sel;
    logic [3:0]  rv, er, rdy;
    logic [31:0] rdat [4];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        dmem_if #(.DATA_W(32), .ADDR_W(32)) u_if ();
        assign u_if.i_req   = req & sel[k];
        assign u_if.i_wen   = wen;
        assign u_if.i_addr  = addr;
        assign u_if.i_be    = be;
        assign u_if.i_wdata = wdata;
        assign rv[k]   = u_if.o_rvalid;
        assign er[k]   = u_if.o_err;
        assign rdy[k]  = u_if.o_ready;
        assign rdat[k] = u_if.o_rdata;
        dmem_lat #(
            .DATA_W     (32),
            .ADDR_W     (32),
            .DEPTH      (64),
            .RD_LAT     (k == 1 ? 1 : (k == 2 ? 4 : 2)),
            .BASE_ADDR  (k == 3 ? 32'h1000 : 32'h0),
            .INIT_CLEAR (1'b1)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (u_if)
        );
    end

    function automatic int lat(input int k);
        return k == 1 ? 1 : (k == 2 ? 4 : 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a negedge; releases reset at a negedge and watches o_ready rise after 64 edges.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", 32'(rv), 0);
        chk("rst_err", 32'(er), 0);
        chk("rst_ready", 32'(rdy), 0);
        rst_n = 1'b1;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (j == 1)  chk("init_rvalid", 32'(rv), 0);
            if (j == 63) chk("init_ready_63", 32'(rdy), 0);
            if (j == 64) chk("init_ready_64", 32'(rdy), 32'hF);
        end
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        sel   = 4'(1 << k);
        req   = 1'b1;
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        be    = b;
        @(negedge clk);
        req = 1'b0;
        wen = 1'b0;
    endtask

    task automatic rd_chk(input int k, input logic [31:0] a, input logic [31:0] ed, input logic ee);
        sel  = 4'(1 << k);
        req  = 1'b1;
        wen  = 1'b0;
        addr = a;
        @(negedge clk);
        req = 1'b0;
        for (int c = 1; c < lat(k); c++) begin
            chk($sformatf("d%0d_early_rvalid_%h", k, a), 32'(rv[k]), 0);
            @(negedge clk);
        end
        chk($sformatf("d%0d_rvalid_%h", k, a), 32'(rv[k]), 1);
        chk($sformatf("d%0d_rdata_%h", k, a), rdat[k], ed);
        chk($sformatf("d%0d_err_%h", k, a), 32'(er[k]), 32'(ee));
        @(negedge clk);
        chk($sformatf("d%0d_late_rvalid_%h", k, a), 32'(rv[k]), 0);
    endtask

    task automatic wr_err(input int k, input logic [31:0] a, input logic [31:0] d);
        wr(k, a, d, 4'hF);
        for (int c = 1; c < lat(k); c++) begin
            chk($sformatf("d%0d_werr_early", k), 32'(er[k]), 0);
            @(negedge clk);
        end
        chk($sformatf("d%0d_werr", k), 32'(er[k]), 1);
        chk($sformatf("d%0d_werr_rvalid", k), 32'(rv[k]), 0);
        @(negedge clk);
        chk($sformatf("d%0d_werr_late", k), 32'(er[k]), 0);
    endtask

    // Reads 0x00/0x04/0x08 on consecutive edges; response j appears after edge j+L-1.
    task automatic b2b(input int k);
        int j;
        sel = 4'(1 << k);
        wen = 1'b0;
        for (int c = 1; c <= lat(k) + 3; c++) begin
            req  = (c <= 3);
            addr = 32'(4 * (c - 1));
            @(negedge clk);
            j = c - lat(k) + 1;
            chk($sformatf("d%0d_b2b_rvalid_%0d", k, c), 32'(rv[k]), 32'(j >= 1 && j <= 3));
            if (j >= 1 && j <= 3) chk($sformatf("d%0d_b2b_rdata_%0d", k, c), rdat[k], 32'(j));
        end
        req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        wen   = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        sel   = '0;
        repeat (2) @(negedge clk);
        do_reset();

        for (int k = 0; k < 3; k++) begin
            rd_chk(k, 32'h10, 32'h0, 1'b0);
            wr(k, 32'h4, 32'h12345678, 4'hF);
            rd_chk(k, 32'h4, 32'h12345678, 1'b0);
            wr(k, 32'h4, 32'hAABBCCDD, 4'h5);
            rd_chk(k, 32'h4, 32'h12BB56DD, 1'b0);
            wr(k, 32'h0, 32'h1, 4'hF);
            wr(k, 32'h4, 32'h2, 4'hF);
            wr(k, 32'h8, 32'h3, 4'hF);
            b2b(k);
        end

        rd_chk(0, 32'h102, 32'h0, 1'b1);
        rd_chk(0, 32'h100, 32'h0, 1'b1);
        wr_err(0, 32'h100, 32'hFFFFFFFF);
        rd_chk(0, 32'h0, 32'h1, 1'b0);
        wr(0, 32'h8, 32'h5, 4'h0);
        rd_chk(0, 32'h8, 32'h3, 1'b0);
        rd_chk(3, 32'hFFC, 32'h0, 1'b1);
        rd_chk(3, 32'h0, 32'h0, 1'b1);
        rd_chk(3, 32'h1000, 32'h0, 1'b0);

        // Two errored reads in flight on DUT0, reset lands while the first is on the output.
        sel  = 4'b0001;
        req  = 1'b1;
        wen  = 1'b0;
        addr = 32'h102;
        @(negedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("inflight_rvalid", 32'(rv[0]), 1);
        chk("inflight_err", 32'(er[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rvalid", 32'(rv[0]), 0);
        chk("async_err", 32'(er[0]), 0);
        @(negedge clk);
        do_reset();
        rd_chk(0, 32'h4, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
